// File: rtl/fir_seq_pkg.sv
// Shared types and default sizing for the FIR MAC sequencer.
package fir_seq_pkg;

  localparam int FIR_NUM_TAPS    = 32;
  localparam int FIR_WORD_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap address counter: steps 0..NUM_TAPS-1 while enabled, wraps at the last tap.
module fir_tap_counter
  import fir_seq_pkg::*;
#(
  parameter int NUM_TAPS   = FIR_NUM_TAPS,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  terminal
);

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);

  assign terminal = (count == LAST_TAP);

  // Clear outranks stepping so an aborted pass always restarts from tap 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR MAC: one sample in, NUM_TAPS MAC steps, one result out.
// Optional sticky overrun detection is built only when FIR_SEQ_OVERRUN_EN is defined.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int WORD_LENGTH = FIR_WORD_LENGTH,
  parameter int NUM_TAPS    = FIR_NUM_TAPS,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  abort,
  output logic                  mac_enable,
  output logic [ADDR_WIDTH-1:0] tap_addr,
  output logic                  first_tap,
  output logic                  mac_clear,
  output logic                  result_capture,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overrun
);

  if ($clog2(NUM_TAPS) != ADDR_WIDTH || WORD_LENGTH < 1) begin : g_bad_params
    $error("fir_mac_sequencer: ADDR_WIDTH must equal clog2(NUM_TAPS) and WORD_LENGTH must be positive");
  end

  fir_state_e state_q;
  fir_state_e state_d;
  logic       idle_ready;
  logic       last_tap;

  fir_tap_counter #(
    .NUM_TAPS  (NUM_TAPS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_tap_counter (
    .clk     (clk),
    .reset   (reset),
    .enable  (mac_enable),
    .clear   (mac_clear),
    .count   (tap_addr),
    .terminal(last_tap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort is tested before the last-tap check so it wins over the wrap into DONE.
  always_comb begin
    state_d        = state_q;
    idle_ready     = 1'b0;
    mac_enable     = 1'b0;
    first_tap      = 1'b0;
    mac_clear      = 1'b0;
    result_capture = 1'b0;
    case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (sample_valid) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        mac_enable = 1'b1;
        first_tap  = (tap_addr == '0);
        if (abort) begin
          mac_clear = 1'b1;
          state_d   = IDLE;
        end else if (last_tap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        mac_clear      = 1'b1;
        result_capture = !abort;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sample_ready = idle_ready & ~reset;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
    end else begin
      result_valid <= result_capture;
    end
  end

`ifdef FIR_SEQ_OVERRUN_EN
  // A sample offered while a computation is in flight is lost; remember it until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (sample_valid && !sample_ready) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: tap-level reference model plus directed scenarios.
module tb_fir_mac_sequencer;

  localparam int N  = 32;
  localparam int AW = 5;
`ifdef FIR_SEQ_OVERRUN_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic          sample_ready;
  logic          abort;
  logic          mac_enable;
  logic [AW-1:0] tap_addr;
  logic          first_tap;
  logic          mac_clear;
  logic          result_capture;
  logic          result_valid;
  logic          busy;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: phase -1 = waiting for a sample, 0..N-1 = tap being processed, N = result cycle.
  int phase   = -1;
  bit rv_pend = 1'b0;
  bit ovf     = 1'b0;

  int acc_total = 0, en_total = 0, first_total = 0, rc_total = 0, rv_total = 0;
  int last_acc = 0, prev_acc = 0, last_rc = 0, last_rv = 0, prev_rv = 0;
  int acc0, en0, first0, rc0, rv0;

  fir_mac_sequencer #(
    .WORD_LENGTH(16),
    .NUM_TAPS   (N),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .abort         (abort),
    .mac_enable    (mac_enable),
    .tap_addr      (tap_addr),
    .first_tap     (first_tap),
    .mac_clear     (mac_clear),
    .result_capture(result_capture),
    .result_valid  (result_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic modelCheck();
    bit in_acc, in_done, e_ready, e_cap;
    @(negedge clk);
    in_acc  = !reset && phase >= 0 && phase < N;
    in_done = !reset && phase == N;
    e_ready = !reset && phase < 0;
    e_cap   = in_done && !abort;
    checkOutput("sample_ready", sample_ready, e_ready);
    checkOutput("busy", busy, in_acc || in_done);
    checkOutput("mac_enable", mac_enable, in_acc);
    checkOutput("tap_addr", tap_addr, in_acc ? phase : 0);
    checkOutput("first_tap", first_tap, in_acc && phase == 0);
    checkOutput("mac_clear", mac_clear, (in_acc && abort) || in_done);
    checkOutput("result_capture", result_capture, e_cap);
    checkOutput("result_valid", result_valid, !reset && rv_pend);
    checkOutput("overrun", overrun, !reset && ovf);
    if (sample_ready && sample_valid) begin
      prev_acc = last_acc; last_acc = cyc; acc_total++;
    end
    if (mac_enable)     en_total++;
    if (first_tap)      first_total++;
    if (result_capture) begin last_rc = cyc; rc_total++; end
    if (result_valid)   begin prev_rv = last_rv; last_rv = cyc; rv_total++; end
    if (reset) begin
      phase = -1; rv_pend = 1'b0; ovf = 1'b0;
    end else begin
      if (OVF_ON && sample_valid && !e_ready) ovf = 1'b1;
      rv_pend = e_cap;
      if (phase < 0)                phase = sample_valid ? 0 : -1;
      else if (abort || phase == N) phase = -1;
      else                          phase++;
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input bit sv, input bit ab);
    nextEdge();
    sample_valid = sv;
    abort        = ab;
    modelCheck();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic snapshot();
    acc0 = acc_total; en0 = en_total; first0 = first_total; rc0 = rc_total; rv0 = rv_total;
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; abort = 1'b0;
    modelCheck();
    modelCheck();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tap", tap_addr, 0);
    checkOutput("reset_result_valid", result_valid, 0);
    checkOutput("reset_overrun", overrun, 0);
    nextEdge();
    reset = 1'b0;
    modelCheck();
    checkOutput("release_ready", sample_ready, 1);

    $display("[TB] single sample");
    snapshot();
    applyStimulus(1'b1, 1'b0);
    idleCycles(40);
    checkOutput("t1_enable_cycles", en_total - en0, N);
    checkOutput("t1_first_tap_count", first_total - first0, 1);
    checkOutput("t1_capture_offset", last_rc - last_acc, N + 1);
    checkOutput("t1_valid_offset", last_rv - last_acc, N + 2);
    checkOutput("t1_valid_count", rv_total - rv0, 1);

    $display("[TB] sample during computation");
    snapshot();
    applyStimulus(1'b1, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_overrun_set", overrun, OVF_ON);
    idleCycles(40);
    checkOutput("t5_overrun_sticky", overrun, OVF_ON);
    checkOutput("t5_accepts", acc_total - acc0, 1);
    checkOutput("t5_valid_count", rv_total - rv0, 1);

    $display("[TB] abort at tap 10");
    snapshot();
    applyStimulus(1'b1, 1'b0);
    idleCycles(10);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3_abort_tap", tap_addr, 10);
    checkOutput("t3_abort_clear", mac_clear, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_idle_busy", busy, 0);
    checkOutput("t3_idle_ready", sample_ready, 1);
    idleCycles(36);
    checkOutput("t3_enable_cycles", en_total - en0, 11);
    checkOutput("t3_no_capture", rc_total - rc0, 0);
    checkOutput("t3_no_valid", rv_total - rv0, 0);

    $display("[TB] abort at last tap");
    snapshot();
    applyStimulus(1'b1, 1'b0);
    idleCycles(31);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_abort_tap", tap_addr, 31);
    checkOutput("t4_abort_clear", mac_clear, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_no_done_busy", busy, 0);
    checkOutput("t4_no_done_capture", result_capture, 0);
    idleCycles(36);
    checkOutput("t4_no_capture", rc_total - rc0, 0);
    checkOutput("t4_no_valid", rv_total - rv0, 0);

    $display("[TB] reset mid-computation");
    snapshot();
    applyStimulus(1'b1, 1'b0);
    idleCycles(20);
    nextEdge();
    sample_valid = 1'b0;
    abort        = 1'b0;
    #1;
    checkOutput("t6_tap_before_reset", tap_addr, 20);
    reset = 1'b1;
    #1;
    checkOutput("t6_enable", mac_enable, 0);
    checkOutput("t6_tap", tap_addr, 0);
    checkOutput("t6_first_tap", first_tap, 0);
    checkOutput("t6_clear", mac_clear, 0);
    checkOutput("t6_capture", result_capture, 0);
    checkOutput("t6_valid", result_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_overrun", overrun, 0);
    modelCheck();
    nextEdge();
    reset = 1'b0;
    modelCheck();
    checkOutput("t6_ready_after_release", sample_ready, 1);
    idleCycles(36);
    checkOutput("t6_no_valid", rv_total - rv0, 0);

    $display("[TB] continuous samples");
    snapshot();
    for (int i = 0; i < 3 * (N + 2) + 1; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(36);
    checkOutput("t2_accepts", acc_total - acc0, 4);
    checkOutput("t2_valid_count", rv_total - rv0, 4);
    checkOutput("t2_accept_period", last_acc - prev_acc, N + 2);
    checkOutput("t2_valid_period", last_rv - prev_rv, N + 2);
    checkOutput("t2_overrun", overrun, OVF_ON);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
